// File: rtl/stl_wrr_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// stl_wrr_pkt_arbiter - weighted round-robin, packet-locking valid/ready arbiter
// Option macro STL_WRR_BEAT_CREDIT_EN: debit credit per beat instead of packet.
// Revision: 1.0
// ============================================================================
module stl_wrr_pkt_arbiter #(
  parameter  int REQ_N = 4,
  parameter  int DAT_W = 32,
  parameter  int WGT_W = 4,
  localparam int ID_W  = $clog2(REQ_N)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_upd_i,
  input  logic [REQ_N-1:0][WGT_W-1:0]  cfg_wgt_i,
  input  logic [REQ_N-1:0]             req_vld_i,
  input  logic [REQ_N-1:0][DAT_W-1:0]  req_dat_i,
  input  logic [REQ_N-1:0]             req_lst_i,
  output logic [REQ_N-1:0]             req_rdy_o,
  output logic                         grt_vld_o,
  output logic [DAT_W-1:0]             grt_dat_o,
  output logic                         grt_lst_o,
  output logic [ID_W-1:0]              grt_id_o,
  input  logic                         grt_rdy_i
);

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LOCK   = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [ID_W-1:0]              ptr_q, ptr_d;
  logic [ID_W-1:0]              own_q, own_d;
  logic [REQ_N-1:0][WGT_W-1:0]  wgt_q, wgt_d;
  logic [REQ_N-1:0][WGT_W-1:0]  crd_q, crd_d;

  logic [REQ_N-1:0] elig;
  logic [REQ_N-1:0] wgt_nz;
  logic             any_wgt_vld;
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W:0]    idx;
  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_id;
  logic             hs;
  logic             pkt_end;
  logic             debit;

  // Weight 0 also blocks eligibility so stale credit cannot sneak a grant.
  always_comb begin
    for (int i = 0; i < REQ_N; i++) begin
      wgt_nz[i] = (wgt_q[i] != '0);
      elig[i]   = req_vld_i[i] && (crd_q[i] != '0) && wgt_nz[i];
    end
    any_wgt_vld = |(req_vld_i & wgt_nz);
  end

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 0; k < REQ_N; k++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(REQ_N)) idx = idx - (ID_W+1)'(REQ_N);
      if (!win_found && elig[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = own_q;
    case (state_q)
      ST_ARB: begin
        gnt_vld = win_found;
        gnt_id  = win_id;
      end
      ST_LOCK: begin
        gnt_vld = req_vld_i[own_q];
        gnt_id  = own_q;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt_id  = own_q;
      end
    endcase
  end

  always_comb begin
    grt_vld_o = gnt_vld;
    grt_id_o  = gnt_id;
    grt_dat_o = req_dat_i[gnt_id];
    grt_lst_o = req_lst_i[gnt_id];
    for (int i = 0; i < REQ_N; i++) begin
      req_rdy_o[i] = gnt_vld && grt_rdy_i && (gnt_id == ID_W'(i));
    end
    hs      = gnt_vld && grt_rdy_i;
    pkt_end = hs && grt_lst_o;
`ifdef STL_WRR_BEAT_CREDIT_EN
    debit   = hs;
`else
    debit   = pkt_end;
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    wgt_d   = cfg_upd_i ? cfg_wgt_i : wgt_q;
    crd_d   = crd_q;
    if (debit && (crd_q[gnt_id] != '0)) begin
      crd_d[gnt_id] = crd_q[gnt_id] - WGT_W'(1);
    end
    if (pkt_end) begin
      ptr_d = (gnt_id == ID_W'(REQ_N-1)) ? '0 : gnt_id + ID_W'(1);
    end
    case (state_q)
      ST_ARB: begin
        if (win_found) begin
          if (hs && !grt_lst_o) begin
            own_d   = win_id;
            state_d = ST_LOCK;
          end
        end else if (any_wgt_vld) begin
          state_d = ST_REFILL;
        end
      end
      ST_LOCK: begin
        if (pkt_end) state_d = ST_ARB;
      end
      ST_REFILL: begin
        // A weight write landing on the refill cycle takes effect immediately.
        crd_d   = cfg_upd_i ? cfg_wgt_i : wgt_q;
        state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      own_q   <= '0;
      wgt_q   <= {REQ_N{WGT_W'(1)}};
      crd_q   <= {REQ_N{WGT_W'(1)}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      wgt_q   <= wgt_d;
      crd_q   <= crd_d;
    end
  end

endmodule
`default_nettype wire
